// File: rtl/async_fifo_wr_ctrl.sv
// async_fifo_wr_ctrl: write-domain pointer, full/level/overflow logic of an async FIFO
module async_fifo_wr_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH:0]   i_rd_ptr_gray_sync,
  input  logic                  i_ovf_clr,
  output logic                  o_mem_wr_en,
  output logic [ADDR_WIDTH-1:0] o_wr_addr,
  output logic [ADDR_WIDTH:0]   o_wr_ptr_gray,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic [ADDR_WIDTH:0]   o_level,
  output logic                  o_overflow
);
  localparam int PW = ADDR_WIDTH + 1;
  logic [PW-1:0] wbin_q, wbin_d, wgray_q, wgray_d, level_q, level_d, rbin, rq;
  logic full_q, full_d, af_q, af_d, ovf_q, ovf_d;
  assign rq = i_rd_ptr_gray_sync;
  for (genvar i = 0; i < PW; i++) begin : g_rbin
    assign rbin[i] = ^rq[PW-1:i];
  end
  always_comb begin
    o_mem_wr_en = i_wr_en & ~full_q;
    wbin_d      = wbin_q + PW'(o_mem_wr_en);
    wgray_d     = wbin_d ^ (wbin_d >> 1);
    full_d      = wgray_d == {~rq[PW-1:PW-2], rq[PW-3:0]};
    level_d     = wbin_d - rbin;
    af_d        = level_d >= PW'(AF_THRESH);
    ovf_d       = (i_wr_en & full_q) | (ovf_q & ~i_ovf_clr);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
    end
  end
  assign o_wr_addr     = wbin_q[ADDR_WIDTH-1:0];
  assign o_wr_ptr_gray = wgray_q;
  assign o_full        = full_q;
  assign o_almost_full = af_q;
  assign o_level       = level_q;
  assign o_overflow    = ovf_q;
endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// tb_async_fifo_wr_ctrl: directed vectors through a scoreboard queue and monitor
module tb_async_fifo_wr_ctrl;
  logic clk = 1'b0, rst = 1'b1, wr = 1'b0, clr = 1'b0;
  logic [3:0] rq = '0;
  logic mwe, full, af, ovf;
  logic [2:0] addr;
  logic [3:0] gray, lvl;
  int n_vec = 0, n_bad = 0;
  bit gray_chk = 0;
  logic [14:0] exp_q[$];
  async_fifo_wr_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_wr_en(wr), .i_rd_ptr_gray_sync(rq), .i_ovf_clr(clr),
    .o_mem_wr_en(mwe), .o_wr_addr(addr), .o_wr_ptr_gray(gray), .o_full(full),
    .o_almost_full(af), .o_level(lvl), .o_overflow(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s {mwe,addr,gray,full,af,lvl,ovf} got %b expected %b", name, act, exp);
    end
  endtask
  task automatic step(input logic w, input logic [3:0] r, input logic c,
                      input logic e_mwe, input logic [2:0] e_addr, input logic [3:0] e_gray,
                      input logic e_full, input logic e_af, input logic [3:0] e_lvl, input logic e_ovf);
    @(negedge clk);
    wr = w; rq = r; clr = c;
    exp_q.push_back({e_mwe, e_addr, e_gray, e_full, e_af, e_lvl, e_ovf});
  endtask
  initial begin : monitor
    logic mwe_s;
    logic [3:0] prev_gray;
    logic [14:0] e;
    prev_gray = '0;
    forever begin
      @(negedge clk);
      #1 mwe_s = mwe;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("vec%0d", n_vec), {mwe_s, addr, gray, full, af, lvl, ovf}, e);
      end
      if (gray_chk && gray != prev_gray) begin
        n_vec++;
        if ($countones(gray ^ prev_gray) != 1) begin
          n_bad++;
          $display("FAIL gray_step got %b after %b, required one bit change", gray, prev_gray);
        end
      end
      prev_gray = gray;
    end
  end
  initial begin
    #1 check("reset_state", {1'b0, addr, gray, full, af, lvl, ovf}, '0);
    @(negedge clk) rst = 1'b0;
    step(0, 4'b0000, 0, 0, 0, 4'b0000, 0, 0, 0, 0);
    step(1, 4'b0000, 0, 1, 1, 4'b0001, 0, 0, 1, 0);
    step(1, 4'b0000, 0, 1, 2, 4'b0011, 0, 0, 2, 0);
    step(1, 4'b0000, 0, 1, 3, 4'b0010, 0, 0, 3, 0);
    step(1, 4'b0000, 0, 1, 4, 4'b0110, 0, 0, 4, 0);
    step(1, 4'b0000, 0, 1, 5, 4'b0111, 0, 0, 5, 0);
    step(1, 4'b0000, 0, 1, 6, 4'b0101, 0, 1, 6, 0);
    step(1, 4'b0000, 0, 1, 7, 4'b0100, 0, 1, 7, 0);
    step(1, 4'b0000, 0, 1, 0, 4'b1100, 1, 1, 8, 0);
    step(1, 4'b0000, 0, 0, 0, 4'b1100, 1, 1, 8, 1);
    step(0, 4'b0000, 0, 0, 0, 4'b1100, 1, 1, 8, 1);
    step(1, 4'b0000, 1, 0, 0, 4'b1100, 1, 1, 8, 1);
    step(0, 4'b0000, 1, 0, 0, 4'b1100, 1, 1, 8, 0);
    step(0, 4'b0010, 0, 0, 0, 4'b1100, 0, 0, 5, 0);
    gray_chk = 1;
    step(1, 4'b0110, 0, 1, 1, 4'b1101, 0, 0, 5, 0);
    step(1, 4'b0111, 0, 1, 2, 4'b1111, 0, 0, 5, 0);
    step(1, 4'b0101, 0, 1, 3, 4'b1110, 0, 0, 5, 0);
    step(1, 4'b0100, 0, 1, 4, 4'b1010, 0, 0, 5, 0);
    step(1, 4'b1100, 0, 1, 5, 4'b1011, 0, 0, 5, 0);
    step(1, 4'b1101, 0, 1, 6, 4'b1001, 0, 0, 5, 0);
    step(1, 4'b1111, 0, 1, 7, 4'b1000, 0, 0, 5, 0);
    step(1, 4'b1110, 0, 1, 0, 4'b0000, 0, 0, 5, 0);
    step(1, 4'b1110, 0, 1, 1, 4'b0001, 0, 1, 6, 0);
    @(negedge clk);
    gray_chk = 0;
    wr = 1'b1;
    #2 rst = 1'b1;
    #1 check("async_reset", {1'b0, addr, gray, full, af, lvl, ovf}, '0);
    wr = 1'b0; rq = '0;
    @(negedge clk) rst = 1'b0;
    step(1, 4'b0000, 0, 1, 1, 4'b0001, 0, 0, 1, 0);
    step(1, 4'b0000, 0, 1, 2, 4'b0011, 0, 0, 2, 0);
    step(1, 4'b0000, 0, 1, 3, 4'b0010, 0, 0, 3, 0);
    step(1, 4'b0000, 0, 1, 4, 4'b0110, 0, 0, 4, 0);
    step(1, 4'b0000, 0, 1, 5, 4'b0111, 0, 0, 5, 0);
    step(1, 4'b0000, 0, 1, 6, 4'b0101, 0, 1, 6, 0);
    step(1, 4'b0000, 0, 1, 7, 4'b0100, 0, 1, 7, 0);
    step(1, 4'b0001, 0, 1, 0, 4'b1100, 0, 1, 7, 0);
    step(1, 4'b0001, 0, 1, 1, 4'b1101, 1, 1, 8, 0);
    step(1, 4'b0001, 0, 0, 1, 4'b1101, 1, 1, 8, 1);
    @(negedge clk);
    wr = 1'b0;
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/async_fifo_wr_ctrl.md
# async_fifo_wr_ctrl

Write-side controller for the asynchronous FIFO, running entirely in the write clock domain. It accepts write requests, keeps the binary and Gray-coded write pointers, and drives the memory write address and enable. It derives full, almost-full, fill level and a sticky overflow flag by comparing against the read pointer after it has passed through the two-flop synchronizer into this domain. Its registered Gray pointer is the value the read domain synchronizes.

## Interface
- `ADDR_WIDTH`, default 3. Memory address width; FIFO depth = 2^ADDR_WIDTH (8). Pointers are ADDR_WIDTH+1 bits.
- `AF_THRESH`, default 6. Fill level at or above which `o_almost_full` asserts. Legal range 1 to 2^ADDR_WIDTH.

Ports:
- `i_clk`  in  1  write-domain clock.
- `i_rst`  in  1  asynchronous, active-high reset.
- `i_wr_en`  in  1  write request; one entry per cycle.
- `i_rd_ptr_gray_sync`  in  ADDR_WIDTH+1  read pointer in Gray code, already synchronized into `i_clk`.
- `i_ovf_clr`  in  1  clears the sticky overflow flag.
- `o_mem_wr_en`  out  1  memory write strobe; combinational, equals `i_wr_en & ~o_full`.
- `o_wr_addr`  out  ADDR_WIDTH  memory write address; low bits of the binary write pointer.
- `o_wr_ptr_gray`  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
- `o_full`  out  1  registered full flag.
- `o_almost_full`  out  1  registered; asserted when fill level ≥ AF_THRESH.
- `o_level`  out  ADDR_WIDTH+1  registered, conservative fill level (0 to 2^ADDR_WIDTH).
- `o_overflow`  out  1  sticky; set by a write attempt while full.

## Operation
- Reset value of every register is 0: binary pointer, `o_wr_ptr_gray`, `o_full`, `o_almost_full`, `o_level`, `o_overflow`. Consequently `o_wr_addr` = 0.
- Accept rule: a write is accepted when `i_wr_en` = 1 and `o_full` = 0.
- On accept:
  - wbin_next = wbin + 1, modulo 2^(ADDR_WIDTH+1). Otherwise wbin_next = wbin.
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - Both registers load their next values every cycle.
- Full:
  - full_next = (wgray_next == {~rq[MSB:MSB-1], rq[MSB-2:0]}), where rq = `i_rd_ptr_gray_sync`.
  - `o_full` <= full_next.
- Level:
  - rbin = Gray-to-binary of rq (XOR prefix from the MSB down).
  - `o_level` <= (wbin_next − rbin), modulo 2^(ADDR_WIDTH+1).
  - `o_almost_full` <= (level_next ≥ AF_THRESH).
- Overflow:
  - Set when `i_wr_en` & `o_full`.
  - Otherwise cleared when `i_ovf_clr` = 1.
  - If set and clear occur in the same cycle, set wins.
- A rejected write changes no pointer and does not drive `o_mem_wr_en`.
- Conservatism: because the read pointer is stale by the synchronizer delay, full and level may over-report. They never under-report.

## Timing
- `o_mem_wr_en` is combinational in the cycle of the request. Memory captures data at `o_wr_addr` on that same clock edge.
- `o_wr_addr`, `o_wr_ptr_gray`, `o_full`, `o_level` and `o_almost_full` update on the clock edge after an accepted write. Latency is 1 cycle.
- A change on `i_rd_ptr_gray_sync` is reflected in `o_full`, `o_level` and `o_almost_full` one cycle later.
- The write that fills the last entry raises `o_full` on the following edge. Back-to-back writes can never overfill.
- `o_wr_ptr_gray` changes at most one bit per cycle, including at wrap-around from 2^(ADDR_WIDTH+1)−1 back to 0.
- Mid-operation reset asynchronously zeroes all registers regardless of clock. The first clock edge after `i_rst` deasserts behaves as the first post-reset cycle.
- A simultaneous write accept and read-pointer advance are handled in one cycle: level_next uses both new values.

## Test plan
- Reset, then 8 consecutive writes with rq = 0:
  - `o_wr_addr` steps 0→7.
  - After the 8th write, `o_full` = 1, `o_level` = 8, `o_wr_ptr_gray` = 4'b1100.
  - `o_almost_full` rises the cycle after the 6th write.
- Write while full: `o_mem_wr_en` = 0, pointers unchanged, `o_overflow` = 1 and stays set. Next, pulse `i_ovf_clr` together with another full write: `o_overflow` stays 1. Next, `i_ovf_clr` alone: it clears.
- From full, drive rq = 4'b0010 (binary 3): one cycle later `o_full` = 0, `o_level` = 5, `o_almost_full` = 0.
- Wrap: continuously write while advancing rq to track.
  - After 16 accepted writes, `o_wr_ptr_gray` returns to 4'b0000.
  - A checker confirms exactly one bit changes per increment.
  - `o_full` never asserts while level < 8.
- Assert `i_rst` asynchronously mid-burst between edges: all outputs go to 0 immediately. Then 1 write yields `o_wr_addr` = 1, `o_level` = 1.
- Simultaneous write and read advance at level 7 (rq moves from 0 to gray(1)): `o_level` stays 7 and `o_full` stays 0.
